ldm_stm_sequencer: RTL and testbench

- Multi-cycle controller for ARM block data transfers (LDM/STM, the cmd_ldm class of the ARM decoder).
- Accepts the decoded register list, addressing-mode bits and the base register value.
- Issues one word transfer per register over a req/ack memory handshake, in ascending register order.
- Steers register-file writes, produces the base writeback value and stalls the decode stage while busy.

---
 rtl/ldm_stm_sequencer_if.sv | 49 ++++
 rtl/ldm_stm_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Decode-side inputs, memory req/ack handshake and register-file/writeback controls.
// Defining LDM_ABORT_EN adds mem_abort (into the sequencer) and abort (out of it).
interface ldm_stm_sequencer_if #(parameter int ADDR_W = 32);
  logic              start;
  logic [15:0]       reg_list;
  logic              ldm_p;
  logic              ldm_u;
  logic              ldm_s;
  logic              ldm_w;
  logic              ldm_l;
  logic [3:0]        base_reg;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [3:0]        xfer_reg;
  logic              rf_we;
  logic              user_bank;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_data;
  logic              spsr_restore;
  logic              done;
`ifdef LDM_ABORT_EN
  logic              mem_abort;
  logic              abort;
`endif

  modport master (
`ifdef LDM_ABORT_EN
    input  mem_abort,
    output abort,
`endif
    input  start, reg_list, ldm_p, ldm_u, ldm_s, ldm_w, ldm_l, base_reg, base_addr, mem_ack,
    output busy, mem_req, mem_we, mem_addr, xfer_reg, rf_we, user_bank, wb_en, wb_data,
           spsr_restore, done
  );

  modport slave (
`ifdef LDM_ABORT_EN
    output mem_abort,
    input  abort,
`endif
    output start, reg_list, ldm_p, ldm_u, ldm_s, ldm_w, ldm_l, base_reg, base_addr, mem_ack,
    input  busy, mem_req, mem_we, mem_addr, xfer_reg, rf_we, user_bank, wb_en, wb_data,
           spsr_restore, done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one word per listed register, ascending order.
// Optional transfer abort is enabled by defining LDM_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// CALC   | count registers, form first address and writeback value
// XFER   | one req/ack transfer per remaining register
// DONE   | one-cycle completion, writeback / SPSR restore strobes
module ldm_stm_sequencer #(parameter int ADDR_W = 32) (
  input  logic                 clk,
  input  logic                 rst,
  ldm_stm_sequencer_if.master  bus
);
  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_XFER, S_DONE} state_t;

  state_t            state_q;
  logic [15:0]       list_q, rem_q, rem_d;
  logic              p_q, u_q, s_q, w_q, l_q;
  logic [3:0]        base_reg_q;
  logic [ADDR_W-1:0] base_q;
  logic              busy_q, mem_req_q, mem_we_q, user_bank_q, wb_en_q, spsr_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q, wb_data_q;
  logic [3:0]        xfer_reg_q;
  logic [ADDR_W-1:0] n4, first_addr;
`ifdef LDM_ABORT_EN
  logic              abort_q;
`endif

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_comb begin
    n4    = ADDR_W'(popcount(list_q)) << 2;
    rem_d = rem_q & ~(16'd1 << xfer_reg_q);
    first_addr = base_q;
    case ({p_q, u_q})
      2'b01:   first_addr = base_q;
      2'b11:   first_addr = base_q + WORD;
      2'b00:   first_addr = base_q - n4 + WORD;
      default: first_addr = base_q - n4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      list_q      <= '0;
      rem_q       <= '0;
      {p_q, u_q, s_q, w_q, l_q} <= '0;
      base_reg_q  <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      xfer_reg_q  <= '0;
      user_bank_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_data_q   <= '0;
      spsr_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LDM_ABORT_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            list_q      <= bus.reg_list;
            p_q         <= bus.ldm_p;
            u_q         <= bus.ldm_u;
            s_q         <= bus.ldm_s;
            w_q         <= bus.ldm_w;
            l_q         <= bus.ldm_l;
            base_reg_q  <= bus.base_reg;
            base_q      <= bus.base_addr;
            busy_q      <= 1'b1;
            user_bank_q <= bus.ldm_s & ~(bus.ldm_l & bus.reg_list[15]);
            state_q     <= S_CALC;
          end
        end
        S_CALC: begin
          wb_data_q <= u_q ? base_q + n4 : base_q - n4;
          if (list_q == 16'd0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rem_q      <= list_q;
            mem_req_q  <= 1'b1;
            mem_we_q   <= ~l_q;
            mem_addr_q <= first_addr & ~ADDR_W'(3);
            xfer_reg_q <= lowest(list_q);
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
`ifdef LDM_ABORT_EN
          if (bus.mem_abort) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            abort_q   <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else
`endif
          if (bus.mem_ack) begin
            rem_q <= rem_d;
            if (rem_d == 16'd0) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
              // an LDM that reloads its own base keeps the loaded value
              wb_en_q   <= w_q & ~(l_q & list_q[base_reg_q]);
              spsr_q    <= s_q & l_q & list_q[15];
              state_q   <= S_DONE;
            end else begin
              mem_addr_q <= mem_addr_q + WORD;
              xfer_reg_q <= lowest(rem_d);
            end
          end
        end
        default: begin
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          wb_en_q     <= 1'b0;
          spsr_q      <= 1'b0;
          user_bank_q <= 1'b0;
          mem_addr_q  <= '0;
          xfer_reg_q  <= '0;
`ifdef LDM_ABORT_EN
          abort_q     <= 1'b0;
`endif
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.xfer_reg     = xfer_reg_q;
  assign bus.user_bank    = user_bank_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.spsr_restore = spsr_q;
  assign bus.done         = done_q;
`ifdef LDM_ABORT_EN
  assign bus.abort        = abort_q;
  assign bus.rf_we        = mem_req_q & bus.mem_ack & l_q & ~bus.mem_abort;
`else
  assign bus.rf_we        = mem_req_q & bus.mem_ack & l_q;
`endif
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed self-checking bench for ldm_stm_sequencer; covers the abort path when LDM_ABORT_EN is defined.
module tb_ldm_stm_sequencer;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ldm_stm_sequencer_if #(.ADDR_W(32)) bus();
  ldm_stm_sequencer #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] got_addr [16];
  logic [3:0]  got_reg  [16];
  logic        got_we   [16];
  int          n_xfer, rfwe_cnt, first_req, done_cyc;
  logic        got_wb_en, got_spsr, got_ub, hold_bad;
  logic [31:0] got_wb_data;
`ifdef LDM_ABORT_EN
  int          abort_at = -1;
  logic        got_abort;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] list, input logic p, input logic u, input logic s,
                       input logic w, input logic l, input logic [3:0] rn, input logic [31:0] base);
    bus.reg_list = list;  bus.ldm_p = p;  bus.ldm_u = u;  bus.ldm_s = s;
    bus.ldm_w = w;  bus.ldm_l = l;  bus.base_reg = rn;  bus.base_addr = base;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Memory responder and recorder; cycle numbers count from the start cycle (=0).
  task automatic run_op(input int ack_period, input int cyc0);
    int          cyc = cyc0;
    int          wait_cnt = 0;
    logic        last_wait = 1'b0;
    logic [31:0] last_addr = '0;
    n_xfer = 0; rfwe_cnt = 0; first_req = -1; done_cyc = -1;
    got_wb_en = 1'b0; got_wb_data = '0; got_spsr = 1'b0; got_ub = 1'b0; hold_bad = 1'b0;
`ifdef LDM_ABORT_EN
    got_abort = 1'b0;
`endif
    while (cyc < 60 && done_cyc < 0) begin
`ifdef LDM_ABORT_EN
      bus.mem_abort = 1'b0;
`endif
      if (bus.mem_req) begin
        if (first_req < 0) begin
          first_req = cyc;
          got_ub = bus.user_bank;
        end
        if (last_wait && bus.mem_addr !== last_addr) hold_bad = 1'b1;
        wait_cnt++;
        bus.mem_ack = (wait_cnt >= ack_period);
`ifdef LDM_ABORT_EN
        if (n_xfer == abort_at) begin
          bus.mem_abort = 1'b1;
          bus.mem_ack = 1'b1;
        end
        if (bus.mem_ack && !bus.mem_abort && n_xfer < 16) begin
`else
        if (bus.mem_ack && n_xfer < 16) begin
`endif
          got_addr[n_xfer] = bus.mem_addr;
          got_reg[n_xfer]  = bus.xfer_reg;
          got_we[n_xfer]   = bus.mem_we;
          n_xfer++;
        end
        last_wait = !bus.mem_ack;
        last_addr = bus.mem_addr;
        if (bus.mem_ack) wait_cnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        last_wait = 1'b0;
      end
      #1;
      if (bus.rf_we) rfwe_cnt++;
      if (bus.done) begin
        done_cyc = cyc;
        got_wb_en = bus.wb_en;
        got_wb_data = bus.wb_data;
        got_spsr = bus.spsr_restore;
`ifdef LDM_ABORT_EN
        got_abort = bus.abort;
`endif
      end
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    bus.mem_ack = 1'b0;
`ifdef LDM_ABORT_EN
    bus.mem_abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.reg_list = '0; bus.ldm_p = 0; bus.ldm_u = 0; bus.ldm_s = 0;
    bus.ldm_w = 0; bus.ldm_l = 0; bus.base_reg = '0; bus.base_addr = '0; bus.mem_ack = 0;
`ifdef LDM_ABORT_EN
    bus.mem_abort = 0;
`endif
    repeat (3) tick();
    checks++; if ({bus.busy, bus.mem_req, bus.mem_we, bus.rf_we, bus.user_bank, bus.wb_en, bus.spsr_restore, bus.done} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b expected 00000000", {bus.busy, bus.mem_req, bus.mem_we, bus.rf_we, bus.user_bank, bus.wb_en, bus.spsr_restore, bus.done}); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.xfer_reg !== 4'h0) begin errors++; $display("FAIL reset_xfer_reg: got %h expected 0", bus.xfer_reg); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", bus.wb_data); end
`ifdef LDM_ABORT_EN
    checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ldmia();
    logic [31:0] ea [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    issue(16'h000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h1000);
    checks++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ldmia_calc: got busy=%b req=%b expected busy=1 req=0", bus.busy, bus.mem_req); end
    run_op(1, 1);
    checks++; if (first_req !== 2) begin errors++; $display("FAIL ldmia_first_req: got %0d expected 2", first_req); end
    checks++; if (n_xfer !== 4) begin errors++; $display("FAIL ldmia_n_xfer: got %0d expected 4", n_xfer); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_addr[i] !== ea[i] || got_reg[i] !== 4'(i) || got_we[i] !== 1'b0) begin errors++; $display("FAIL ldmia_xfer%0d: got addr=%h reg=%0d we=%b expected addr=%h reg=%0d we=0", i, got_addr[i], got_reg[i], got_we[i], ea[i], i); end
    end
    checks++; if (rfwe_cnt !== 4) begin errors++; $display("FAIL ldmia_rf_we: got %0d expected 4", rfwe_cnt); end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL ldmia_done_cyc: got %0d expected 6", done_cyc); end
    checks++; if (got_wb_en !== 1'b1 || got_wb_data !== 32'h1010) begin errors++; $display("FAIL ldmia_wb: got en=%b data=%h expected en=1 data=00001010", got_wb_en, got_wb_data); end
    checks++; if (got_spsr !== 1'b0) begin errors++; $display("FAIL ldmia_spsr: got %b expected 0", got_spsr); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL ldmia_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_stmdb_wait();
    logic [31:0] ea [3] = '{32'h1FF4, 32'h1FF8, 32'h1FFC};
    logic [3:0]  er [3] = '{4'd0, 4'd8, 4'd15};
    issue(16'h8101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 32'h2000);
    run_op(3, 1);
    checks++; if (n_xfer !== 3) begin errors++; $display("FAIL stmdb_n_xfer: got %0d expected 3", n_xfer); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_addr[i] !== ea[i] || got_reg[i] !== er[i] || got_we[i] !== 1'b1) begin errors++; $display("FAIL stmdb_xfer%0d: got addr=%h reg=%0d we=%b expected addr=%h reg=%0d we=1", i, got_addr[i], got_reg[i], got_we[i], ea[i], er[i]); end
    end
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL stmdb_addr_hold: got moved=%b expected 0", hold_bad); end
    checks++; if (rfwe_cnt !== 0) begin errors++; $display("FAIL stmdb_rf_we: got %0d expected 0", rfwe_cnt); end
    checks++; if (done_cyc !== 11) begin errors++; $display("FAIL stmdb_done_cyc: got %0d expected 11", done_cyc); end
    checks++; if (got_wb_en !== 1'b1 || got_wb_data !== 32'h1FF4) begin errors++; $display("FAIL stmdb_wb: got en=%b data=%h expected en=1 data=00001ff4", got_wb_en, got_wb_data); end
    tick();
  endtask

  task automatic test_ldmib_base_in_list();
    issue(16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h3000);
    run_op(1, 1);
    checks++; if (n_xfer !== 2 || got_addr[0] !== 32'h3004 || got_reg[0] !== 4'd1 || got_addr[1] !== 32'h3008 || got_reg[1] !== 4'd2) begin errors++; $display("FAIL ldmib_xfers: got n=%0d %h/r%0d %h/r%0d expected n=2 00003004/r1 00003008/r2", n_xfer, got_addr[0], got_reg[0], got_addr[1], got_reg[1]); end
    checks++; if (rfwe_cnt !== 2) begin errors++; $display("FAIL ldmib_rf_we: got %0d expected 2", rfwe_cnt); end
    checks++; if (done_cyc !== 4 || got_wb_en !== 1'b0) begin errors++; $display("FAIL ldmib_wb_suppress: got done=%0d wb_en=%b expected done=4 wb_en=0", done_cyc, got_wb_en); end
    tick();
  endtask

  task automatic test_s_bit();
    issue(16'h8001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h4000);
    run_op(1, 1);
    checks++; if (got_ub !== 1'b0 || got_spsr !== 1'b1) begin errors++; $display("FAIL ldm_s_pc: got user_bank=%b spsr=%b expected 0 1", got_ub, got_spsr); end
    checks++; if (got_reg[1] !== 4'd15 || got_addr[1] !== 32'h4004 || got_wb_en !== 1'b0) begin errors++; $display("FAIL ldm_s_pc_xfer: got r%0d %h wb_en=%b expected r15 00004004 wb_en=0", got_reg[1], got_addr[1], got_wb_en); end
    tick();
    issue(16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h5000);
    run_op(1, 1);
    checks++; if (got_ub !== 1'b1 || got_spsr !== 1'b0) begin errors++; $display("FAIL stm_s_user: got user_bank=%b spsr=%b expected 1 0", got_ub, got_spsr); end
    tick();
  endtask

  task automatic test_empty_and_busy_start();
    issue(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h6000);
    run_op(1, 1);
    checks++; if (first_req !== -1 || done_cyc !== 2 || got_wb_en !== 1'b0) begin errors++; $display("FAIL empty_list: got first_req=%0d done=%0d wb_en=%b expected -1 2 0", first_req, done_cyc, got_wb_en); end
    bus.reg_list = 16'hFFFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b expected 0", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL start_in_done_idle: got busy=%b req=%b expected 0 0", bus.busy, bus.mem_req); end
    issue(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h7000);
    bus.reg_list = 16'hFFFF;
    bus.base_addr = 32'h0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_op(1, 2);
    checks++; if (n_xfer !== 2 || got_addr[1] !== 32'h7004 || done_cyc !== 4) begin errors++; $display("FAIL start_while_busy: got n=%0d addr1=%h done=%0d expected 2 00007004 4", n_xfer, got_addr[1], done_cyc); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(16'h000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h8000);
    bus.mem_ack = 1'b1;
    tick();
    tick();
    checks++; if (bus.mem_addr !== 32'h8004 || bus.xfer_reg !== 4'd1) begin errors++; $display("FAIL mid_second_xfer: got %h r%0d expected 00008004 r1", bus.mem_addr, bus.xfer_reg); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.busy, bus.mem_req, bus.mem_we, bus.rf_we, bus.user_bank, bus.wb_en, bus.spsr_restore, bus.done} !== 8'h00) begin errors++; $display("FAIL mid_reset_flags: got %b expected 00000000", {bus.busy, bus.mem_req, bus.mem_we, bus.rf_we, bus.user_bank, bus.wb_en, bus.spsr_restore, bus.done}); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.xfer_reg !== 4'h0 || bus.wb_data !== 32'h0) begin errors++; $display("FAIL mid_reset_values: got addr=%h reg=%h wb=%h expected 0 0 0", bus.mem_addr, bus.xfer_reg, bus.wb_data); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy || bus.done || bus.wb_en || bus.mem_req) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_idle: got %0d active cycles expected 0", seen); end
    bus.mem_ack = 1'b0;
  endtask

`ifdef LDM_ABORT_EN
  task automatic test_abort();
    issue(16'h000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h9000);
    abort_at = 1;
    run_op(1, 1);
    abort_at = -1;
    checks++; if (rfwe_cnt !== 1) begin errors++; $display("FAIL abort_rf_we: got %0d expected 1", rfwe_cnt); end
    checks++; if (got_abort !== 1'b1 || got_wb_en !== 1'b0 || got_spsr !== 1'b0 || done_cyc !== 4) begin errors++; $display("FAIL abort_done: got abort=%b wb_en=%b spsr=%b done=%0d expected 1 0 0 4", got_abort, got_wb_en, got_spsr, done_cyc); end
    tick();
    checks++; if (bus.abort !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_clear: got abort=%b busy=%b expected 0 0", bus.abort, bus.busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb_wait();
    test_ldmib_base_in_list();
    test_s_bit();
    test_empty_and_busy_start();
    test_reset_mid();
`ifdef LDM_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
